// File: rtl/dvp_capture_pkg.sv
// Shared types and helpers for the OV2640 DVP capture stage.
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SKIP   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  localparam logic MODE_RAW10  = 1'b0;
  localparam logic MODE_RGB565 = 1'b1;

  localparam int CNT_W = 12;

  // Grey expansion: replicate the sensor MSBs into all three colour fields.
  function automatic logic [15:0] raw10_to_565(input logic [9:4] d);
    return {d[9:5], d[9:4], d[9:5]};
  endfunction

endpackage

// File: rtl/dvp_pixel_packer.sv
// Turns registered DVP samples into 16-bit pixels (RAW10 grey or two-byte RGB565).
module dvp_pixel_packer
  import dvp_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        href,
  input  logic [9:2]  data,
  input  logic        mode,
  output logic        pixel_done,
  output logic [15:0] pixel
);

  logic       phase;
  logic [7:0] hi_byte;

  // Byte phase tracks position within an RGB565 pair; idle lines restart at phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= 1'b0;
      hi_byte <= 8'd0;
    end else if (!href) begin
      phase <= 1'b0;
    end else if (mode == MODE_RGB565) begin
      phase <= ~phase;
      if (!phase) begin
        hi_byte <= data[9:2];
      end
    end else begin
      phase <= 1'b0;
    end
  end

  // Pixel completes on every RAW10 sample, or on the second byte of an RGB565 pair.
  always_comb begin
    pixel_done = 1'b0;
    pixel      = 16'd0;
    if (!href) begin
      pixel_done = 1'b0;
    end else if (mode == MODE_RAW10) begin
      pixel_done = 1'b1;
      pixel      = raw10_to_565(data[9:4]);
    end else if (phase) begin
      pixel_done = 1'b1;
      pixel      = {hi_byte, data[9:2]};
    end else begin
      pixel_done = 1'b0;
    end
  end

endmodule

// File: rtl/dvp_capture.sv
// OV2640 DVP ingest: settle-frame skipping, fixed-window crop, frame counting
// and sticky geometry errors, producing an RGB565 frame-buffer write stream.
module dvp_capture
  import dvp_capture_pkg::*;
#(
  parameter int H_RES       = 800,
  parameter int V_RES       = 600,
  parameter int SKIP_FRAMES = 2,
  parameter bit VS_POL      = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_enable,
  input  logic        I_mode,
  input  logic        I_err_clr,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [9:0]  I_data,
  output logic        O_vs_n,
  output logic        O_de,
  output logic [15:0] O_data,
  output logic [15:0] O_frame_cnt,
  output logic [1:0]  O_err
);

  localparam logic [CNT_W-1:0] H_LIM     = CNT_W'(H_RES);
  localparam logic [CNT_W-1:0] V_LIM     = CNT_W'(V_RES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       SKIP_INIT = 8'(SKIP_FRAMES);

  logic             vs_d, href_d, vs_prev, href_prev, mode_q;
  logic [9:0]       data_d;
  logic             vs_act, fs, href_v, line_end, gate;
  state_t           state, state_nxt;
  logic [7:0]       skip_cnt, skip_nxt;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic             pixel_done;
  logic [15:0]      pixel;
  logic             de_p;
  logic [15:0]      pix_p;
  logic [1:0]       err_set;
  logic             unused_lsbs;

  // The two sensor LSBs never reach the 16-bit output in either format.
  assign unused_lsbs = ^data_d[1:0];

  assign vs_act   = (vs_d == VS_POL);
  assign fs       = vs_act && !vs_prev;
  assign href_v   = href_d && !vs_act;
  assign line_end = href_prev && !href_v;

  dvp_pixel_packer u_packer (
    .clk        (I_clk),
    .rst        (I_rst),
    .href       (href_v),
    .data       (data_d[9:2]),
    .mode       (mode_q),
    .pixel_done (pixel_done),
    .pixel      (pixel)
  );

  // Stream FSM acts only at frame start; gate also covers the entry frame's fs cycle.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    if (fs) begin
      case (state)
        S_IDLE: begin
          if (!I_enable) begin
            state_nxt = S_IDLE;
          end else if (SKIP_FRAMES == 0) begin
            state_nxt = S_STREAM;
          end else begin
            state_nxt = S_SKIP;
            skip_nxt  = SKIP_INIT;
          end
        end
        S_SKIP: begin
          if (!I_enable) begin
            state_nxt = S_IDLE;
          end else if (skip_cnt <= 8'd1) begin
            state_nxt = S_STREAM;
            skip_nxt  = 8'd0;
          end else begin
            skip_nxt = skip_cnt - 8'd1;
          end
        end
        S_STREAM: begin
          if (!I_enable) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_STREAM;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      state_nxt = state;
    end
    gate = ((state == S_STREAM) && !(fs && !I_enable)) ||
           ((state != S_STREAM) && (state_nxt == S_STREAM));
  end

  // Geometry checks only count while the frame is being streamed.
  always_comb begin
    err_set    = 2'b00;
    err_set[0] = gate && line_end && (x_cnt < H_LIM) && (y_cnt < V_LIM);
    err_set[1] = gate && fs && (state == S_STREAM) && (y_cnt < V_LIM);
  end

  // Input sampling, edge history, FSM state and mode latch.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      vs_d      <= 1'b0;
      href_d    <= 1'b0;
      data_d    <= 10'd0;
      vs_prev   <= 1'b0;
      href_prev <= 1'b0;
      state     <= S_IDLE;
      skip_cnt  <= 8'd0;
      mode_q    <= MODE_RAW10;
    end else begin
      vs_d      <= I_vsync;
      href_d    <= I_href;
      data_d    <= I_data;
      vs_prev   <= vs_act;
      href_prev <= href_v;
      state     <= state_nxt;
      skip_cnt  <= skip_nxt;
      if (fs) begin
        mode_q <= I_mode;
      end
    end
  end

  // Saturating pixel and line position counters.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (!href_v) begin
        x_cnt <= '0;
      end else if (pixel_done && (x_cnt != CNT_MAX)) begin
        x_cnt <= x_cnt + 12'd1;
      end
      if (fs) begin
        y_cnt <= '0;
      end else if (line_end && (y_cnt != CNT_MAX)) begin
        y_cnt <= y_cnt + 12'd1;
      end
    end
  end

  // Crop stage then output registers; a set event beats a same-cycle clear.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      de_p        <= 1'b0;
      pix_p       <= 16'd0;
      O_de        <= 1'b0;
      O_data      <= 16'd0;
      O_vs_n      <= 1'b1;
      O_frame_cnt <= 16'd0;
      O_err       <= 2'b00;
    end else begin
      de_p   <= pixel_done && gate && (x_cnt < H_LIM) && (y_cnt < V_LIM);
      pix_p  <= pixel;
      O_de   <= de_p;
      if (de_p) begin
        O_data <= pix_p;
      end
      O_vs_n <= ~(vs_act && gate);
      if (fs && gate) begin
        O_frame_cnt <= O_frame_cnt + 16'd1;
      end
      O_err <= (I_err_clr ? 2'b00 : O_err) | err_set;
    end
  end

endmodule

// File: tb/tb_dvp_capture.sv
// Directed table-driven bench for dvp_capture on a 4x3 window with one skip frame.
module tb_dvp_capture;

  logic        clk = 1'b0;
  logic        rst, enable, mode, err_clr, vsync, href;
  logic [9:0]  data;
  logic        o_vs_n, o_de;
  logic [15:0] o_data, o_frame_cnt;
  logic [1:0]  o_err;

  int total = 0;
  int bad   = 0;
  int de_total = 0;
  int vs_total = 0;
  logic [15:0] last_data = 16'd0;

  typedef struct {
    logic        en;
    logic        en_mid;
    logic        mode;
    logic        clr;
    int          lines;
    int          width;
    logic [9:0]  d0;
    logic [9:0]  d1;
    int          exp_de;
    logic        exp_vs;
    logic [15:0] exp_data;
    logic [1:0]  exp_err;
    logic [15:0] exp_fcnt;
  } vec_t;

  vec_t vecs[13];

  dvp_capture #(
    .H_RES(4), .V_RES(3), .SKIP_FRAMES(1), .VS_POL(1'b1)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_enable(enable), .I_mode(mode),
    .I_err_clr(err_clr), .I_vsync(vsync), .I_href(href), .I_data(data),
    .O_vs_n(o_vs_n), .O_de(o_de), .O_data(o_data),
    .O_frame_cnt(o_frame_cnt), .O_err(o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_de) begin
        de_total  <= de_total + 1;
        last_data <= o_data;
      end
      if (!o_vs_n) begin
        vs_total <= vs_total + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int de0, vs0;
    de0 = de_total;
    vs0 = vs_total;
    enable = v.en;
    mode   = v.mode;
    vs_pulse();
    enable = v.en_mid;
    if (v.clr) begin
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
    end
    tick(2);
    for (int l = 0; l < v.lines; l++) begin
      for (int b = 0; b < v.width; b++) begin
        href = 1'b1;
        data = b[0] ? v.d1 : v.d0;
        tick(1);
      end
      href = 1'b0;
      data = 10'd0;
      tick(3);
    end
    tick(4);
    check($sformatf("v%0d de_count", idx), de_total - de0, v.exp_de);
    check($sformatf("v%0d vs_seen", idx), {31'd0, vs_total != vs0}, {31'd0, v.exp_vs});
    if (v.exp_de > 0) begin
      check($sformatf("v%0d data", idx), {16'd0, last_data}, {16'd0, v.exp_data});
    end
    check($sformatf("v%0d err", idx), {30'd0, o_err}, {30'd0, v.exp_err});
    check($sformatf("v%0d frame_cnt", idx), {16'd0, o_frame_cnt}, {16'd0, v.exp_fcnt});
  endtask

  initial begin
    //          en    mid   mode  clr  L  W  d0      d1      de  vs    data      err    fcnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 4, 10'h3FF, 10'h3FF, 0,  1'b0, 16'h0000, 2'b00, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 4, 10'h3FF, 10'h3FF, 12, 1'b1, 16'hFFFF, 2'b00, 16'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 4, 10'h200, 10'h200, 12, 1'b1, 16'h8410, 2'b00, 16'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 2, 10'h3E0, 10'h07C, 1,  1'b1, 16'hF81F, 2'b01, 16'd3};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 9, 10'h3E0, 10'h07C, 4,  1'b1, 16'hF81F, 2'b00, 16'd4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 6, 10'h3FF, 10'h3FF, 12, 1'b1, 16'hFFFF, 2'b00, 16'd5};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 4, 10'h155, 10'h155, 8,  1'b1, 16'h52AA, 2'b00, 16'd6};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 3, 10'h3FF, 10'h3FF, 9,  1'b1, 16'hFFFF, 2'b11, 16'd7};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 4, 10'h200, 10'h200, 12, 1'b1, 16'h8410, 2'b00, 16'd8};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 4, 10'h3FF, 10'h3FF, 12, 1'b1, 16'hFFFF, 2'b00, 16'd9};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 4, 10'h200, 10'h200, 0,  1'b0, 16'h0000, 2'b00, 16'd9};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 4, 10'h200, 10'h200, 0,  1'b0, 16'h0000, 2'b00, 16'd9};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 4, 10'h155, 10'h155, 12, 1'b1, 16'h52AA, 2'b00, 16'd10};

    rst = 1'b1; enable = 1'b0; mode = 1'b0; err_clr = 1'b0;
    vsync = 1'b0; href = 1'b0; data = 10'd0;
    tick(3);
    check("reset vs_n", {31'd0, o_vs_n}, 32'd1);
    check("reset de", {31'd0, o_de}, 32'd0);
    check("reset data", {16'd0, o_data}, 32'd0);
    check("reset frame_cnt", {16'd0, o_frame_cnt}, 32'd0);
    check("reset err", {30'd0, o_err}, 32'd0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 13; i++) begin
      run_frame(i, vecs[i]);
    end

    // RGB565 pair latency: pixel appears two clocks after the second byte is sampled
    mode = 1'b1;
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(4);
    href = 1'b1;
    data = 10'h3E0;
    tick(1);
    data = 10'h07C;
    tick(1);
    href = 1'b0;
    data = 10'd0;
    check("lat +0 de", {31'd0, o_de}, 32'd0);
    tick(1);
    check("lat +1 de", {31'd0, o_de}, 32'd0);
    tick(1);
    check("lat +2 de", {31'd0, o_de}, 32'd1);
    check("lat +2 data", {16'd0, o_data}, 32'h0000F81F);
    tick(1);
    check("lat +3 de", {31'd0, o_de}, 32'd0);
    tick(6);
    check("lat frame_cnt", {16'd0, o_frame_cnt}, 32'd11);

    // Asynchronous reset in the middle of a streamed line
    mode = 1'b0;
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(4);
    href = 1'b1;
    data = 10'h3FF;
    tick(4);
    check("pre-reset de", {31'd0, o_de}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid reset de", {31'd0, o_de}, 32'd0);
    check("mid reset vs_n", {31'd0, o_vs_n}, 32'd1);
    check("mid reset data", {16'd0, o_data}, 32'd0);
    check("mid reset frame_cnt", {16'd0, o_frame_cnt}, 32'd0);
    check("mid reset err", {30'd0, o_err}, 32'd0);
    href = 1'b0;
    data = 10'd0;
    tick(2);
    rst = 1'b0;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      run_frame(100 + i, vecs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
